// File: rtl/jstk_dir_reader.sv
// PmodJSTK reader: SPI mode-0 poll, X/Y/button capture, dead-zone direction classifier and debounce.
// Optional JSTK_LED_EN: drives the joystick LED command in byte 0; otherwise MOSI stays low.
module jstk_dir_reader #(
    parameter int SCLK_HALF      = 100,
    parameter int SS_SETUP       = 1500,
    parameter int BYTE_GAP       = 1000,
    parameter int POLL_CYCLES    = 1000000,
    parameter int DEADZONE       = 128,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MISO,
    output logic       SS,
    output logic       MOSI,
    output logic       SCLK,
    input  logic [1:0] led_cmd,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] btn,
    output logic       sample_valid,
    output logic [2:0] DIR,
    output logic       dir_valid
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE, DECODE} state_t;
    typedef enum logic [2:0] {D_NONE = 3'd0, D_UP = 3'd1, D_DOWN = 3'd2,
                              D_LEFT = 3'd3, D_RIGHT = 3'd4} dir_t;

    localparam int TMAX_A = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int TMAX   = (TMAX_A > SCLK_HALF) ? TMAX_A : SCLK_HALF;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int PW     = $clog2(POLL_CYCLES + 1);
    localparam int CW     = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] STAB = CW'(STABLE_SAMPLES);
    localparam logic [10:0]   DZ   = 11'(DEADZONE);

    state_t        state, state_next;
    logic [TW-1:0] tmr;
    logic [PW-1:0] poll_cnt;
    logic [2:0]    bit_idx, byte_idx;
    logic [7:0]    rx_sr, x_lo, y_lo;
    logic [1:0]    x_hi, y_hi;
    logic [2:0]    btn_raw;
    dir_t          cand, cls, cand_new;
    logic [CW-1:0] cnt, cnt_new;
    logic          dir_change;

    logic half_done, setup_done, gap_done, byte_end;
    assign half_done  = (tmr == TW'(SCLK_HALF - 1));
    assign setup_done = (tmr == TW'(SS_SETUP - 1));
    assign gap_done   = (tmr == TW'(BYTE_GAP - 1));
    assign byte_end   = (state == SHIFT) && half_done && SCLK && (bit_idx == 3'd7);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (poll_cnt == '0) state_next = SETUP;
            SETUP:   if (setup_done) state_next = SHIFT;
            SHIFT:   if (byte_end) state_next = GAP;
            GAP:     if (gap_done) state_next = (byte_idx < 3'd4) ? SHIFT : DONE;
            DONE:    state_next = DECODE;
            DECODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Direction from the registered sample; ties between axes resolve vertically.
    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    always_comb begin
        dx  = $signed({1'b0, x_pos}) - 11'sd512;
        dy  = $signed({1'b0, y_pos}) - 11'sd512;
        adx = dx[10] ? 11'(-dx) : 11'(dx);
        ady = dy[10] ? 11'(-dy) : 11'(dy);
        cls = D_NONE;
        if (adx > DZ || ady > DZ) begin
            if (ady >= adx) cls = (!dy[10] && dy != 11'sd0) ? D_UP : D_DOWN;
            else            cls = (!dx[10] && dx != 11'sd0) ? D_RIGHT : D_LEFT;
        end
        if (cls == cand) begin
            cand_new = cand;
            cnt_new  = (cnt == STAB) ? cnt : cnt + 1'b1;
        end else begin
            cand_new = cls;
            cnt_new  = CW'(1);
        end
        dir_change = (cnt_new == STAB) && (cand_new != dir_t'(DIR));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SS           <= 1'b1;
            SCLK         <= 1'b0;
            tmr          <= '0;
            poll_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            rx_sr        <= '0;
            x_lo         <= '0;
            x_hi         <= '0;
            y_lo         <= '0;
            y_hi         <= '0;
            btn_raw      <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            btn          <= '0;
            sample_valid <= 1'b0;
            cand         <= D_NONE;
            cnt          <= '0;
            DIR          <= D_NONE;
            dir_valid    <= 1'b0;
        end else begin
            SS           <= !(state_next inside {SETUP, SHIFT, GAP});
            poll_cnt     <= (poll_cnt == PW'(POLL_CYCLES - 1)) ? '0 : poll_cnt + 1'b1;
            sample_valid <= (state == DONE);
            dir_valid    <= (state == DECODE) && dir_change;

            if (state_next != state || (state == SHIFT && half_done)) tmr <= '0;
            else                                                      tmr <= tmr + 1'b1;

            if (state == IDLE) begin
                bit_idx  <= '0;
                byte_idx <= '0;
            end

            // Rising half samples MISO; falling half advances the bit and files a full byte.
            if (state == SHIFT && half_done) begin
                SCLK <= !SCLK;
                if (!SCLK) begin
                    rx_sr <= {rx_sr[6:0], MISO};
                end else if (bit_idx == 3'd7) begin
                    bit_idx <= '0;
                    case (byte_idx)
                        3'd0:    x_lo    <= rx_sr;
                        3'd1:    x_hi    <= rx_sr[1:0];
                        3'd2:    y_lo    <= rx_sr;
                        3'd3:    y_hi    <= rx_sr[1:0];
                        default: btn_raw <= rx_sr[2:0];
                    endcase
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end

            if (state == GAP && gap_done && byte_idx < 3'd4) byte_idx <= byte_idx + 1'b1;

            if (state == DONE) begin
                x_pos <= {x_hi, x_lo};
                y_pos <= {y_hi, y_lo};
                btn   <= btn_raw;
            end

            if (state == DECODE) begin
                cand <= cand_new;
                cnt  <= cnt_new;
                if (dir_change) DIR <= cand_new;
            end
        end
    end

`ifdef JSTK_LED_EN
    // Byte 0 carries the LED command latched as SS falls; later bytes shift out zeros.
    logic [7:0] tx_sr;
    always_ff @(posedge CLK) begin
        if (RST)
            tx_sr <= '0;
        else if (state == IDLE && state_next == SETUP)
            tx_sr <= {6'b100000, led_cmd};
        else if (state == SHIFT && half_done && SCLK)
            tx_sr <= {tx_sr[6:0], 1'b0};
    end
    assign MOSI = tx_sr[7];
`else
    logic unused_led;
    assign unused_led = ^led_cmd;
    assign MOSI       = 1'b0;
`endif

endmodule

// File: tb/tb_jstk_dir_reader.sv
// Directed bench for jstk_dir_reader: SPI slave model feeding two readers (STABLE_SAMPLES 1 and 3).
// Expected LED byte follows the JSTK_LED_EN build macro.
module tb_jstk_dir_reader;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MISO;
    logic [1:0] led_cmd = 2'b10;

    logic       SS, MOSI, SCLK, sample_valid, dv1;
    logic [9:0] x_pos, y_pos;
    logic [2:0] btn, dir1;

    logic       unused_ss3, unused_mosi3, unused_sclk3, unused_sv3, dv3;
    logic [9:0] unused_x3, unused_y3;
    logic [2:0] unused_btn3, dir3;

    always #5 CLK = ~CLK;

    jstk_dir_reader #(.SCLK_HALF(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_CYCLES(200),
                      .DEADZONE(128), .STABLE_SAMPLES(1)) u1 (
        .CLK(CLK), .RST(RST), .MISO(MISO), .SS(SS), .MOSI(MOSI), .SCLK(SCLK),
        .led_cmd(led_cmd), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
        .sample_valid(sample_valid), .DIR(dir1), .dir_valid(dv1));

    jstk_dir_reader #(.SCLK_HALF(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_CYCLES(200),
                      .DEADZONE(128), .STABLE_SAMPLES(3)) u3 (
        .CLK(CLK), .RST(RST), .MISO(MISO), .SS(unused_ss3), .MOSI(unused_mosi3),
        .SCLK(unused_sclk3), .led_cmd(led_cmd), .x_pos(unused_x3), .y_pos(unused_y3),
        .btn(unused_btn3), .sample_valid(unused_sv3), .DIR(dir3), .dir_valid(dv3));

    // Slave: MISO presents the current bit MSB first, advancing after each SCLK rise.
    logic [7:0] tx_bytes [5];
    logic [5:0] rise_cnt = '0, last_rises = '0;
    logic [7:0] mosi_sh = '0, mosi_b0 = '0;
    logic       mosi_rest = 1'b0, last_rest = 1'b0;

    always_comb begin
        MISO = 1'b0;
        if (rise_cnt < 6'd40) MISO = tx_bytes[rise_cnt[5:3]][~rise_cnt[2:0]];
    end

    always @(posedge SCLK or posedge SS) begin
        if (SS) begin
            last_rises <= rise_cnt;
            last_rest  <= mosi_rest;
            rise_cnt   <= '0;
            mosi_rest  <= 1'b0;
        end else begin
            if (rise_cnt < 6'd8)  mosi_sh <= {mosi_sh[6:0], MOSI};
            if (rise_cnt == 6'd7) mosi_b0 <= {mosi_sh[6:0], MOSI};
            if (rise_cnt >= 6'd8 && MOSI) mosi_rest <= 1'b1;
            rise_cnt <= rise_cnt + 1'b1;
        end
    end

    int sv1_cnt = 0, dv3_cnt = 0;
    always @(posedge CLK) begin
        if (sample_valid) sv1_cnt <= sv1_cnt + 1;
        if (dv3)          dv3_cnt <= dv3_cnt + 1;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_slave(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        tx_bytes[0] = x[7:0];
        tx_bytes[1] = {6'b101010, x[9:8]};
        tx_bytes[2] = y[7:0];
        tx_bytes[3] = {6'b110011, y[9:8]};
        tx_bytes[4] = {5'b10110, b};
    endtask

    task automatic wait_sample();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            if (sample_valid) seen = 1'b1;
        end
        check("sample_arrived", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_dirs(input string tag, input logic [2:0] e1, input logic ev1,
                              input logic [2:0] e3, input logic ev3);
        check({tag, "_dir1"}, {29'd0, dir1}, {29'd0, e1});
        check({tag, "_dv1"},  {31'd0, dv1},  {31'd0, ev1});
        check({tag, "_dir3"}, {29'd0, dir3}, {29'd0, e3});
        check({tag, "_dv3"},  {31'd0, dv3},  {31'd0, ev3});
    endtask

    task automatic do_txn(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] e1, input logic ev1, input logic [2:0] e3, input logic ev3);
        load_slave(x, y, 3'b000);
        wait_sample();
        @(negedge CLK);
        check_dirs(tag, e1, ev1, e3, ev3);
    endtask

    logic [7:0] exp_b0;
    int         sv_before;

    initial begin
`ifdef JSTK_LED_EN
        exp_b0 = 8'h82;
`else
        exp_b0 = 8'h00;
`endif
        // Reset state
        load_slave(10'd1000, 10'd512, 3'b101);
        repeat (5) @(negedge CLK);
        check("rst_ss",    {31'd0, SS},   32'd1);
        check("rst_sclk",  {31'd0, SCLK}, 32'd0);
        check("rst_mosi",  {31'd0, MOSI}, 32'd0);
        check("rst_xpos",  {22'd0, x_pos}, 32'd0);
        check_dirs("rst", 3'd0, 1'b0, 3'd0, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        check("ss_fall", {31'd0, SS}, 32'd0);

        // First sample: X=1000, Y=512 -> right
        wait_sample();
        check("t1_x",     {22'd0, x_pos}, 32'd1000);
        check("t1_y",     {22'd0, y_pos}, 32'd512);
        check("t1_btn",   {29'd0, btn},   32'd5);
        check("t1_rises", {26'd0, last_rises}, 32'd40);
        check("t1_mosi0", {24'd0, mosi_b0},    {24'd0, exp_b0});
        check("t1_mosir", {31'd0, last_rest},  32'd0);
        @(negedge CLK);
        check_dirs("t1", 3'd4, 1'b1, 3'd0, 1'b0);

        // Dead-zone boundaries and tie
        do_txn("t2_dz_edge", 10'd640, 10'd384, 3'd0, 1'b1, 3'd0, 1'b0);
        do_txn("t3_dz_out",  10'd641, 10'd384, 3'd4, 1'b1, 3'd0, 1'b0);
        check("t3_x", {22'd0, x_pos}, 32'd641);
        do_txn("t4_down",    10'd700, 10'd188, 3'd2, 1'b1, 3'd0, 1'b0);
        do_txn("t5_tie_up",  10'd700, 10'd700, 3'd1, 1'b1, 3'd0, 1'b0);

        // Settle the STABLE=3 reader on left, then up,up,left,up,up,up
        do_txn("t6_left",  10'd100, 10'd512, 3'd3, 1'b1, 3'd0, 1'b0);
        do_txn("t7_left",  10'd100, 10'd512, 3'd3, 1'b0, 3'd0, 1'b0);
        do_txn("t8_left",  10'd100, 10'd512, 3'd3, 1'b0, 3'd3, 1'b1);
        do_txn("t9_up",    10'd512, 10'd1000, 3'd1, 1'b1, 3'd3, 1'b0);
        do_txn("t10_up",   10'd512, 10'd1000, 3'd1, 1'b0, 3'd3, 1'b0);
        do_txn("t11_left", 10'd100, 10'd512, 3'd3, 1'b1, 3'd3, 1'b0);
        do_txn("t12_up",   10'd512, 10'd1000, 3'd1, 1'b1, 3'd3, 1'b0);
        do_txn("t13_up",   10'd512, 10'd1000, 3'd1, 1'b0, 3'd3, 1'b0);
        do_txn("t14_up",   10'd512, 10'd1000, 3'd1, 1'b0, 3'd1, 1'b1);
        do_txn("t15_up",   10'd512, 10'd1000, 3'd1, 1'b0, 3'd1, 1'b0);
        check("dv3_total", dv3_cnt, 32'd2);

        // Reset in the middle of byte 2
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 400 && !hit; i++) begin
                @(negedge CLK);
                if (rise_cnt == 6'd20) hit = 1'b1;
            end
            check("reach_byte2", {31'd0, hit}, 32'd1);
        end
        sv_before = sv1_cnt;
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_ss",   {31'd0, SS},   32'd1);
        check("mid_rst_sclk", {31'd0, SCLK}, 32'd0);
        check("mid_rst_x",    {22'd0, x_pos}, 32'd0);
        check_dirs("mid_rst", 3'd0, 1'b0, 3'd0, 1'b0);
        load_slave(10'd512, 10'd20, 3'b010);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("no_partial_sv", sv1_cnt, sv_before);
        check("post_rst_ss",   {31'd0, SS}, 32'd0);
        wait_sample();
        check("pr_x",     {22'd0, x_pos}, 32'd512);
        check("pr_y",     {22'd0, y_pos}, 32'd20);
        check("pr_btn",   {29'd0, btn},   32'd2);
        check("pr_rises", {26'd0, last_rises}, 32'd40);
        @(negedge CLK);
        check_dirs("pr", 3'd2, 1'b1, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
